// File: rtl/ll_walker.sv
// ll_walker: fetches a chain of DMA descriptors and hands each valid one to the channel engine
module ll_walker #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DESC_WDS = 6,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_ptr,
  input  logic              abort,
  output logic              ll_req,
  output logic [ADDR_W-1:0] ll_addr,
  input  logic              ll_ack,
  input  logic              ll_dvld,
  input  logic [DATA_W-1:0] ll_rdata,
  input  logic [2:0]        ll_dcnt,
  output logic              desc_vld,
  input  logic              desc_rdy,
  output logic [DATA_W-1:0] desc_ctrl,
  output logic [DATA_W-1:0] desc_src,
  output logic [DATA_W-1:0] desc_dst,
  output logic [DATA_W-1:0] desc_len,
  output logic [DATA_W-1:0] desc_next,
  output logic [DATA_W-1:0] desc_attr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  desc_cnt
);
  typedef enum logic [2:0] {IDLE, REQ, DATA, OUT, FIN} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] ptr, nxt_ptr;
  logic [DATA_W-1:0] w [DESC_WDS];
  logic abort_q, err_q, beat, last_beat, stop;
  assign beat      = state == DATA && ll_dvld && int'(ll_dcnt) < DESC_WDS;
  assign last_beat = beat && int'(ll_dcnt) == DESC_WDS - 1;
  assign stop      = abort || abort_q;
  assign ll_addr   = ptr;
  assign desc_vld  = state == OUT;
  assign done      = state == FIN;
  assign err       = done && err_q;
  assign desc_ctrl = w[0];
  assign desc_src  = w[1];
  assign desc_dst  = w[2];
  assign desc_len  = w[3];
  assign desc_next = w[4];
  assign desc_attr = w[5];
  // next state and next pointer; a pointer with low bits set is never requested
  always_comb begin
    nxt     = state;
    nxt_ptr = ptr;
    case (state)
      IDLE: if (start) begin
        nxt     = REQ;
        nxt_ptr = head_ptr;
      end
      REQ:  nxt = (ll_req && ll_ack) ? DATA : (ptr[1:0] != 2'b0 || stop) ? FIN : REQ;
      DATA: nxt = last_beat ? (w[0][0] ? OUT : FIN) : DATA;
      OUT:  if (desc_rdy) begin
        nxt_ptr = ADDR_W'(w[4]);
        nxt     = (w[0][1] || w[4] == '0 || stop) ? FIN : REQ;
      end
      default: nxt = IDLE;
    endcase
  end
  // control registers; ll_req is raised on entry to REQ so it is glitch-free
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= '0;
      ll_req   <= 1'b0;
      busy     <= 1'b0;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      desc_cnt <= '0;
    end else begin
      state    <= nxt;
      ptr      <= nxt_ptr;
      ll_req   <= nxt == REQ && nxt_ptr[1:0] == 2'b0;
      busy     <= nxt != IDLE;
      abort_q  <= state == IDLE ? 1'b0 : abort_q || abort;
      err_q    <= state == IDLE ? 1'b0 : err_q || (state == REQ && ptr[1:0] != 2'b0);
      desc_cnt <= (state == IDLE && start) ? '0 : desc_cnt + CNT_W'(state == OUT && desc_rdy);
    end
  end
  // descriptor word capture indexed by the beat counter; out-of-range beats are dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DESC_WDS; i++) w[i] <= '0;
    end else if (beat) begin
      w[ll_dcnt] <= ll_rdata;
    end
  end
endmodule

// File: tb/tb_ll_walker.sv
// tb_ll_walker: directed checks of descriptor chain walking
module tb_ll_walker;
  logic        clk = 0, rstn = 0, start = 0, abort = 0;
  logic [31:0] head_ptr = 0;
  logic        ll_req, ll_ack = 0, ll_dvld = 0;
  logic [31:0] ll_addr, ll_rdata = 0;
  logic [2:0]  ll_dcnt = 0;
  logic        desc_vld, desc_rdy = 1;
  logic [31:0] desc_ctrl, desc_src, desc_dst, desc_len, desc_next, desc_attr;
  logic        busy, done, err;
  logic [15:0] desc_cnt;
  int errors = 0, checks = 0, n_done = 0, beat_no = -1;
  logic err_at_done, busy_after;
  logic [31:0] resp_a;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] fetch_q [$];
  logic [31:0] src_q [$];
  logic [31:0] len_q [$];

  ll_walker dut (
    .clk(clk), .rstn(rstn), .start(start), .head_ptr(head_ptr), .abort(abort),
    .ll_req(ll_req), .ll_addr(ll_addr), .ll_ack(ll_ack), .ll_dvld(ll_dvld),
    .ll_rdata(ll_rdata), .ll_dcnt(ll_dcnt), .desc_vld(desc_vld), .desc_rdy(desc_rdy),
    .desc_ctrl(desc_ctrl), .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .desc_next(desc_next), .desc_attr(desc_attr), .busy(busy), .done(done), .err(err),
    .desc_cnt(desc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // memory side: acknowledge one cycle after a request, then stream six beats
  always begin
    @(posedge clk); #1;
    if (ll_req && rstn) begin
      fetch_q.push_back(ll_addr);
      resp_a = ll_addr;
      ll_ack = 1;
      @(posedge clk); #1;
      ll_ack = 0;
      for (int i = 0; i < 6; i++) begin
        ll_dvld = 1; ll_dcnt = 3'(i); ll_rdata = mem[resp_a + 32'(4 * i)]; beat_no = i;
        @(posedge clk); #1;
      end
      ll_dvld = 0; ll_dcnt = 0; beat_no = -1;
    end
  end

  // handoffs and done pulses observed mid-cycle
  always @(negedge clk) begin
    if (desc_vld && desc_rdy) begin
      src_q.push_back(desc_src);
      len_q.push_back(desc_len);
    end
    if (done) n_done++;
  end

  task automatic set_desc(input logic [31:0] a, c, s, d, l, n, at);
    mem[a] = c; mem[a + 4] = s; mem[a + 8] = d; mem[a + 12] = l; mem[a + 16] = n; mem[a + 20] = at;
  endtask

  task automatic clear_obs();
    fetch_q.delete(); src_q.delete(); len_q.delete(); n_done = 0;
  endtask

  task automatic start_walk(input logic [31:0] a);
    @(posedge clk); #1;
    head_ptr = a; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 500; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    if (k == 500) check("done_timeout", 0, 1);
    err_at_done = err;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [191:0] snap;
    int bad, k;
    logic saw_req;
    #12;
    check("rst_req", ll_req, 0);
    check("rst_outs", {busy, done, err, desc_vld}, 0);
    check("rst_cnt_addr", {desc_cnt, ll_addr}, 0);
    check("rst_fields", {desc_ctrl, desc_src, desc_len, desc_next}, 0);
    rstn = 1;

    // single node
    set_desc(32'h1000, 32'h3, 32'hA000, 32'hB000, 32'h40, 0, 32'h55);
    clear_obs();
    start_walk(32'h1000);
    wait_done();
    idle(10);
    check("single_fetches", fetch_q.size(), 1);
    check("single_addr", fetch_q[0], 32'h1000);
    check("single_handoffs", src_q.size(), 1);
    check("single_src", src_q[0], 32'hA000);
    check("single_len", len_q[0], 32'h40);
    check("single_cnt", desc_cnt, 1);
    check("single_done", n_done, 1);
    check("single_err", err_at_done, 0);
    check("single_attr", desc_attr, 32'h55);

    // chain of three, with a start while busy that must be ignored
    set_desc(32'h1000, 32'h1, 32'hA100, 0, 32'h10, 32'h2000, 0);
    set_desc(32'h2000, 32'h1, 32'hA200, 0, 32'h20, 32'h3000, 0);
    set_desc(32'h3000, 32'h3, 32'hA300, 0, 32'h30, 32'h4000, 0);
    clear_obs();
    start_walk(32'h1000);
    idle(2);
    start_walk(32'h5000);
    wait_done();
    idle(10);
    check("chain_fetches", fetch_q.size(), 3);
    check("chain_order", {fetch_q[0], fetch_q[1]}, {32'h1000, 32'h2000});
    check("chain_third", fetch_q[2], 32'h3000);
    check("chain_srcs", {src_q[0], src_q[1], src_q[2]}, {32'hA100, 32'hA200, 32'hA300});
    check("chain_cnt", desc_cnt, 3);
    check("chain_done", n_done, 1);

    // second node invalid
    set_desc(32'h1000, 32'h1, 32'hA100, 0, 32'h10, 32'h2000, 0);
    set_desc(32'h2000, 32'h0, 32'hA200, 0, 32'h20, 32'h3000, 0);
    clear_obs();
    start_walk(32'h1000);
    wait_done();
    idle(10);
    check("inv_fetches", fetch_q.size(), 2);
    check("inv_handoffs", src_q.size(), 1);
    check("inv_cnt", desc_cnt, 1);
    check("inv_done", n_done, 1);

    // backpressure on the first of two nodes
    set_desc(32'h1000, 32'h1, 32'hC100, 32'hD100, 32'h80, 32'h2000, 32'h77);
    set_desc(32'h2000, 32'h3, 32'hC200, 32'hD200, 32'h90, 0, 0);
    clear_obs();
    desc_rdy = 0;
    start_walk(32'h1000);
    for (k = 0; k < 200 && !desc_vld; k++) idle(1);
    check("bp_vld_seen", desc_vld, 1);
    snap = {desc_ctrl, desc_src, desc_dst, desc_len, desc_next, desc_attr};
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!desc_vld || ll_req || snap !== {desc_ctrl, desc_src, desc_dst, desc_len, desc_next, desc_attr}) bad++;
      idle(1);
    end
    check("bp_stable", bad, 0);
    check("bp_src", desc_src, 32'hC100);
    check("bp_one_fetch", fetch_q.size(), 1);
    desc_rdy = 1;
    wait_done();
    idle(10);
    check("bp_fetches", fetch_q.size(), 2);
    check("bp_cnt", desc_cnt, 2);

    // misaligned head pointer
    clear_obs();
    saw_req = 0;
    @(posedge clk); #1;
    head_ptr = 32'h1002; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (k = 0; k < 50 && !done; k++) begin
      saw_req |= ll_req;
      idle(1);
    end
    check("mis_done", done, 1);
    check("mis_err", err, 1);
    idle(1);
    check("mis_busy_after", busy, 0);
    check("mis_no_req", {saw_req, 32'(fetch_q.size())}, 0);
    check("mis_err_once", err, 0);

    // abort during data beat 2
    set_desc(32'h1000, 32'h1, 32'hE100, 0, 32'h44, 32'h2000, 0);
    set_desc(32'h2000, 32'h3, 32'hE200, 0, 32'h44, 0, 0);
    clear_obs();
    start_walk(32'h1000);
    for (k = 0; k < 50 && beat_no != 2; k++) idle(1);
    abort = 1;
    idle(1);
    abort = 0;
    wait_done();
    idle(15);
    check("abort_fetches", fetch_q.size(), 1);
    check("abort_handoffs", src_q.size(), 1);
    check("abort_src", src_q[0], 32'hE100);
    check("abort_cnt", desc_cnt, 1);
    check("abort_done", n_done, 1);

    // reset in the middle of data beats
    clear_obs();
    start_walk(32'h1000);
    for (k = 0; k < 50 && beat_no != 3; k++) idle(1);
    rstn = 0;
    #1;
    check("rstmid_ctl", {ll_req, busy, done, err, desc_vld}, 0);
    check("rstmid_cnt_addr", {desc_cnt, ll_addr}, 0);
    check("rstmid_fields", {desc_ctrl, desc_src, desc_next}, 0);
    idle(1);
    rstn = 1;
    idle(10);
    check("rstmid_quiet", {ll_req, busy, desc_vld, 32'(n_done)}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
